// File: rtl/led_mean_div_if.sv
// Result beat bus from led_mean_div to the LED driver: one RGB mean per area
// under a valid/ready handshake.
interface led_mean_div_if;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_area;
    logic [23:0] out_rgb;

    modport master (output out_valid, output out_area, output out_rgb, input out_ready);
    modport slave  (input out_valid, input out_area, input out_rgb, output out_ready);
endinterface

// File: rtl/led_mean_div.sv
// Per-area RGB mean stage: snapshots 16x3 area sums on start and divides each by
// AREA_PIX with one shared restoring divider. Define LED_MEAN_ROUND_EN for round-to-nearest.
module led_mean_div #(
    parameter int AREA_PIX = 6800,
    parameter int SUM_W    = 17,
    parameter int DIV_W    = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] SumR [16],
    input  logic [SUM_W-1:0] SumG [16],
    input  logic [SUM_W-1:0] SumB [16],
    led_mean_div_if.master   out_if,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);
    localparam int REM_W = 14;
    localparam int TRY_W = REM_W + 1;
    localparam logic [TRY_W-1:0] DIVISOR = TRY_W'(AREA_PIX);
    localparam logic [4:0]       LAST_IT = 5'(DIV_W - 1);
`ifdef LED_MEAN_ROUND_EN
    localparam logic [DIV_W-1:0] ROUND_ADD = DIV_W'(AREA_PIX / 2);
`endif

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_OUT} state_t;

    function automatic logic [7:0] sat8(input logic [DIV_W-1:0] q);
        if (q[DIV_W-1:8] != '0) begin
            return 8'hFF;
        end else begin
            return q[7:0];
        end
    endfunction

    state_t           state_q;
    logic [SUM_W-1:0] snap_r_q [16];
    logic [SUM_W-1:0] snap_g_q [16];
    logic [SUM_W-1:0] snap_b_q [16];
    logic [3:0]       a_q;
    logic [1:0]       c_q;
    logic [4:0]       it_q;
    logic [DIV_W-1:0] dq_q;
    logic [REM_W-1:0] rem_q;
    logic [7:0]       acc_r_q, acc_g_q;
    logic             out_valid_q;
    logic [3:0]       out_area_q;
    logic [23:0]      out_rgb_q;
    logic             busy_q, frame_done_q, overrun_q;

    logic [SUM_W-1:0] sel_sum_s;
    logic [DIV_W-1:0] load_div_s;
    logic [TRY_W-1:0] trial_s;
    logic             ge_s;
    logic [REM_W-1:0] rem_d;
    logic [DIV_W-1:0] quot_d;
    logic             hs_s;
    logic             last_hs_s;

    // Operand select and one restoring-division step; dq_q shifts the dividend out and quotient bits in.
    always_comb begin
        sel_sum_s = '0;
        case (c_q)
            2'd0:    sel_sum_s = snap_r_q[a_q];
            2'd1:    sel_sum_s = snap_g_q[a_q];
            default: sel_sum_s = snap_b_q[a_q];
        endcase
`ifdef LED_MEAN_ROUND_EN
        load_div_s = {{(DIV_W-SUM_W-4){1'b0}}, sel_sum_s, 4'b0000} + ROUND_ADD;
`else
        load_div_s = {{(DIV_W-SUM_W-4){1'b0}}, sel_sum_s, 4'b0000};
`endif
        trial_s = {rem_q, dq_q[DIV_W-1]};
        if (trial_s >= DIVISOR) begin
            ge_s  = 1'b1;
            rem_d = REM_W'(trial_s - DIVISOR);
        end else begin
            ge_s  = 1'b0;
            rem_d = trial_s[REM_W-1:0];
        end
        quot_d    = {dq_q[DIV_W-2:0], ge_s};
        hs_s      = (state_q == S_OUT) && out_valid_q && out_if.out_ready;
        last_hs_s = hs_s && (a_q == 4'd15);
    end

    // Sum snapshot, refreshed only by start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_r_q <= '{default: '0};
            snap_g_q <= '{default: '0};
            snap_b_q <= '{default: '0};
        end else if (start) begin
            snap_r_q <= SumR;
            snap_g_q <= SumG;
            snap_b_q <= SumB;
        end
    end

    // Sequencer: LOAD/DIV per channel, OUT per area; start always restarts the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            a_q          <= 4'd0;
            c_q          <= 2'd0;
            it_q         <= 5'd0;
            dq_q         <= '0;
            rem_q        <= '0;
            acc_r_q      <= 8'h00;
            acc_g_q      <= 8'h00;
            out_valid_q  <= 1'b0;
            out_area_q   <= 4'd0;
            out_rgb_q    <= 24'h000000;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (start) begin
                // A start coinciding with the final handshake is a clean back-to-back frame.
                if (busy_q && !last_hs_s) begin
                    overrun_q <= 1'b1;
                end
                frame_done_q <= last_hs_s;
                busy_q       <= 1'b1;
                out_valid_q  <= 1'b0;
                a_q          <= 4'd0;
                c_q          <= 2'd0;
                state_q      <= S_LOAD;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        state_q <= S_IDLE;
                    end
                    S_LOAD: begin
                        dq_q    <= load_div_s;
                        rem_q   <= '0;
                        it_q    <= 5'd0;
                        state_q <= S_DIV;
                    end
                    S_DIV: begin
                        dq_q  <= quot_d;
                        rem_q <= rem_d;
                        it_q  <= it_q + 5'd1;
                        if (it_q == LAST_IT) begin
                            case (c_q)
                                2'd0:    acc_r_q <= sat8(quot_d);
                                2'd1:    acc_g_q <= sat8(quot_d);
                                default: acc_g_q <= acc_g_q;
                            endcase
                            if (c_q == 2'd2) begin
                                out_rgb_q   <= {acc_r_q, acc_g_q, sat8(quot_d)};
                                out_area_q  <= a_q;
                                out_valid_q <= 1'b1;
                                state_q     <= S_OUT;
                            end else begin
                                c_q     <= c_q + 2'd1;
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_OUT: begin
                        if (hs_s) begin
                            out_valid_q <= 1'b0;
                            if (a_q == 4'd15) begin
                                busy_q       <= 1'b0;
                                frame_done_q <= 1'b1;
                                state_q      <= S_IDLE;
                            end else begin
                                a_q     <= a_q + 4'd1;
                                c_q     <= 2'd0;
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    default: begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_area  = out_area_q;
    assign out_if.out_rgb   = out_rgb_q;
    assign busy             = busy_q;
    assign frame_done       = frame_done_q;
    assign overrun          = overrun_q;
endmodule

// File: doc/led_mean_div.md
# led_mean_div

Sequential mean-calculation stage directly downstream of the per-area square adder in the LED ambient path. On the adder's end-of-frame `start` pulse, it snapshots the 16×3 area sums. It then divides each sum by the fixed area pixel count with one shared restoring divider. It emits one 24-bit RGB mean per area, in area order, over a valid/ready handshake to the LED driver.

## Interface
- `AREA_PIX`, 6800: pixels per area (all 16 areas are 20×340); divisor.
- `SUM_W`, 17: width of each incoming sum.
- `DIV_W`, 22: dividend width, {sum,4'b0} plus rounding headroom; also the iteration count per division.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `start`  in  1  end-of-frame pulse from the square adder; sums are valid in this same cycle.
- `SumR`/`SumG`/`SumB`  in  [16:0] ×16 each  per-area channel sums, index = area.
- `out_valid`  out  1  `out_area`/`out_rgb` hold a result.
- `out_ready`  in  1  downstream accepts the beat.
- `out_area`  out  4  area index 0..15.
- `out_rgb`  out  24  {R8,G8,B8} mean, scaled ×16 (nibble mean 0..15 maps to 0..240).
- `busy`  out  1  high from the snapshot until the area-15 handshake.
- `frame_done`  out  1  one-cycle pulse after the area-15 handshake.
- `overrun`  out  1  sticky; set when `start` arrives while `busy`. Cleared only by reset.

## Operation
- Snapshot: when `start`=1, all 48 sums are registered. Area counter `a`=0, channel counter `c`=0 (R, then G, then B). State goes to LOAD.
- States:
  - IDLE: waiting for `start`.
  - LOAD: selects sum[a][c]. Dividend = {sum,4'b0}, zero-extended to DIV_W. Remainder is cleared.
  - DIV: DIV_W restoring iterations, MSB first, one quotient bit per cycle.
  - STORE: folded into the last DIV cycle. The quotient is saturated to 8'hFF if ≥256 and written to byte c.
    - If c<2: c++, go to LOAD.
    - If c=2: go to OUT.
  - OUT: `out_valid`=1 with stable outputs. On `out_valid && out_ready`:
    - If a<15: a++, c=0, go to LOAD.
    - If a=15: go to IDLE, pulse `frame_done`, drop `busy`.
- Quotient = floor(dividend / AREA_PIX), except as modified by the Configuration macro. Remainder width = divisor width + 1 = 14 bits.
- `start` while `busy`: abort the current frame, set `overrun`, re-snapshot, restart at a=0, c=0.
  - `out_valid` drops in the next cycle.
  - A beat in OUT that was not yet handshaken is discarded.
- `start` in the same cycle as the area-15 handshake: the handshake completes, then the new frame starts. `frame_done` still pulses; `overrun` is not set.
- Backpressure: OUT holds indefinitely. Snapshot registers are unaffected by new sums until the next `start`.

## Timing
- Reset values: `out_valid`=0, `out_area`=0, `out_rgb`=0, `busy`=0, `frame_done`=0, `overrun`=0; state=IDLE. Reset mid-frame abandons all work.
- Edge E0 samples `start`. Each channel takes 23 cycles (1 LOAD + 22 DIV).
- With `out_ready` held high:
  - Area k `out_valid` rises after edge E(70k+69).
  - Area k handshake occurs at edge E(70k+70).
  - `frame_done` is high for the cycle after E1120.
  - `busy` rises after E0 and falls after E1120.
- Each cycle of `out_ready`=0 delays all subsequent timing by one cycle.
- `out_area`/`out_rgb` change only on the cycle entering OUT.

## Configuration
- `LED_MEAN_ROUND_EN` defined: AREA_PIX/2 (3400) is added to the dividend in LOAD, giving round-to-nearest. DIV_W=22 covers the worst case, 2097136+3400.
- Not defined: truncating division. The adder in the LOAD path is removed.

## Test plan
- All sums = 102000 for all areas, `start`, `out_ready`=1 → 16 beats, areas 0..15, each `out_rgb`=24'hF0F0F0. Area-0 `out_valid` after E69; `frame_done` after E1120.
- Area 3: R=54400, G=0, B=6800; all other areas 0 → area 3 `out_rgb`=24'h800010; all other areas 24'h000000.
- R=700 in area 0 → R8=8'h01 without `LED_MEAN_ROUND_EN`, 8'h02 with it. R=131071 → 8'hFF (saturated) in both builds.
- Hold `out_ready`=0 for 50 cycles at area 5 → beat stays stable. Area-15 handshake and `frame_done` slip by exactly 50 cycles.
- Second `start` at E500 → `overrun`=1 and stays set. Output restarts at area 0 with the new sums; area-0 `out_valid` after E569.
- Deassert `rst_n` during DIV of area 7 → all outputs at reset values immediately. After release, no beats appear until the next `start`.
